// File: rtl/ab_auto_solver_pkg.sv
// Shared definitions for the 1A2B solver: FSM states, history record, score and BCD helpers.
package ab_auto_solver_pkg;

    typedef enum logic [2:0] {StIdle, StSearch, StPropose, StDone, StFail} state_e;

    localparam int unsigned DigitW    = 4;
    localparam logic [2:0]  WinA      = 3'd4;
    localparam logic [15:0] FirstCand = 16'h0123;
    localparam logic [15:0] LastCand  = 16'h9876;

    typedef struct packed {
        logic [15:0] g;
        logic [2:0]  a;
        logic [2:0]  b;
    } hist_t;

    // A score no secret with distinct digits can produce.
    function automatic logic illegal_score(input logic [2:0] a, input logic [2:0] b);
        return (({1'b0, a} + {1'b0, b}) > 4'd4) || (a == 3'd3 && b == 3'd1);
    endfunction

    function automatic logic has_repeat(input logic [15:0] v);
        logic rep;
        rep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (v[DigitW*i +: DigitW] == v[DigitW*j +: DigitW]) rep = 1'b1;
            end
        end
        return rep;
    endfunction

    function automatic logic [15:0] bcd_next(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[DigitW*i +: DigitW] == 4'd9) begin
                    r[DigitW*i +: DigitW] = 4'd0;
                end else begin
                    r[DigitW*i +: DigitW] = r[DigitW*i +: DigitW] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ab_score.sv
// Combinational bulls/cows score of guess g against reference s (both 4-digit BCD).
module ab_score
    import ab_auto_solver_pkg::*;
(
    input  logic [15:0] g,
    input  logic [15:0] s,
    output logic [2:0]  a,
    output logic [2:0]  b
);

    logic hit;

    always_comb begin
        a   = 3'd0;
        b   = 3'd0;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && g[DigitW*i +: DigitW] == s[DigitW*j +: DigitW]) hit = 1'b1;
            end
            if (g[DigitW*i +: DigitW] == s[DigitW*i +: DigitW]) a = a + 3'd1;
            if (hit) b = b + 3'd1;
        end
    end

endmodule

// File: rtl/ab_auto_solver.sv
// 1A2B code-breaker: walks BCD candidates in order and proposes the first one
// consistent with every guess/score pair recorded so far.
module ab_auto_solver
    import ab_auto_solver_pkg::*;
#(
    parameter int unsigned MAX_GUESS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] guess,
    output logic        guess_valid,
    input  logic [2:0]  a_in,
    input  logic [2:0]  b_in,
    input  logic        score_valid,
    output logic [3:0]  guess_num,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    localparam int unsigned IdxW   = (MAX_GUESS > 1) ? $clog2(MAX_GUESS) : 1;
    localparam logic [3:0]  MaxNum = 4'(MAX_GUESS);

    state_e      state;
    logic [15:0] cand;
    logic [3:0]  idx;
    hist_t       hist [MAX_GUESS];
    hist_t       cur;
    logic [2:0]  sa, sb;
    logic [3:0]  num_inc;

    assign cur     = hist[idx[IdxW-1:0]];
    assign num_inc = guess_num + 4'd1;

    ab_score u_score (
        .g (cand),
        .s (cur.g),
        .a (sa),
        .b (sb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            guess       <= 16'h0000;
            guess_valid <= 1'b0;
            guess_num   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            cand        <= FirstCand;
            idx         <= 4'd0;
            hist        <= '{default: '0};
        end else begin
            case (state)
                StIdle, StDone, StFail: begin
                    if (start) begin
                        state     <= StSearch;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        guess_num <= 4'd0;
                        cand      <= FirstCand;
                        idx       <= 4'd0;
                        hist      <= '{default: '0};
                    end
                end
                StSearch: begin
                    if (has_repeat(cand)) begin
                        cand <= bcd_next(cand);
                        idx  <= 4'd0;
                    end else if (idx == guess_num) begin
                        guess <= cand;
                        state <= StPropose;
                    end else if (sa == cur.a && sb == cur.b) begin
                        idx <= idx + 4'd1;
                    end else if (cand == LastCand) begin
                        state <= StFail;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                    end else begin
                        cand <= bcd_next(cand);
                        idx  <= 4'd0;
                    end
                end
                StPropose: begin
                    // Advertise one cycle after loading so the guess is settled before the scorer sees it.
                    if (!guess_valid) begin
                        guess_valid <= 1'b1;
                    end else if (score_valid) begin
                        guess_valid <= 1'b0;
                        if (illegal_score(a_in, b_in)) begin
                            state <= StFail;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end else begin
                            hist[guess_num[IdxW-1:0]] <= '{g: guess, a: a_in, b: b_in};
                            guess_num <= num_inc;
                            if (a_in == WinA) begin
                                state <= StDone;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (num_inc == MaxNum || cand == LastCand) begin
                                state <= StFail;
                                busy  <= 1'b0;
                                fail  <= 1'b1;
                            end else begin
                                state <= StSearch;
                                cand  <= bcd_next(cand);
                                idx   <= 4'd0;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ab_auto_solver.sv
// Self-checking bench: a smallest-consistent-candidate model predicts every guess; a monitor
// checks stability, distinct digits and consistency of each advertised guess.
module tb_ab_auto_solver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, score_valid = 1'b0;
    logic [2:0]  a_in = 3'd0, b_in = 3'd0;
    logic [15:0] guess;
    logic        guess_valid, busy, done, fail;
    logic [3:0]  guess_num;

    logic        start2 = 1'b0, sv2 = 1'b0;
    logic [2:0]  a2 = 3'd0, b2 = 3'd0;
    logic [15:0] g2;
    logic        gv2, busy2, done2, fail2;
    logic [3:0]  gn2;

    int checks = 0;
    int errors = 0;

    logic [15:0] h_g[$];
    int          h_a[$];
    int          h_b[$];

    logic        prev_valid = 1'b0;
    logic [15:0] prev_guess = 16'h0;

    always #5 clk = ~clk;

    ab_auto_solver #(.MAX_GUESS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .guess(guess), .guess_valid(guess_valid),
        .a_in(a_in), .b_in(b_in), .score_valid(score_valid), .guess_num(guess_num),
        .busy(busy), .done(done), .fail(fail)
    );

    ab_auto_solver #(.MAX_GUESS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .guess(g2), .guess_valid(gv2),
        .a_in(a2), .b_in(b2), .score_valid(sv2), .guess_num(gn2),
        .busy(busy2), .done(done2), .fail(fail2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Score encoded as a*10+b, e.g. 31 means 3A1B.
    function automatic int score(input logic [15:0] g, input logic [15:0] s);
        int a = 0;
        int b = 0;
        for (int i = 0; i < 4; i++) begin
            bit hit = 0;
            if (g[4*i +: 4] == s[4*i +: 4]) a++;
            for (int j = 0; j < 4; j++)
                if (j != i && g[4*i +: 4] == s[4*j +: 4]) hit = 1;
            if (hit) b++;
        end
        return a * 10 + b;
    endfunction

    function automatic bit distinct(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (v[4*i +: 4] == v[4*j +: 4]) return 0;
        return 1;
    endfunction

    function automatic bit consistent(input logic [15:0] c);
        foreach (h_g[k])
            if (score(c, h_g[k]) != h_a[k] * 10 + h_b[k]) return 0;
        return 1;
    endfunction

    // Smallest distinct-digit value agreeing with the whole history; bit 16 = found.
    function automatic logic [16:0] model_next();
        for (int v = 123; v <= 9876; v++) begin
            logic [15:0] c;
            c = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            if (distinct(c) && consistent(c)) return {1'b1, c};
        end
        return 17'h0;
    endfunction

    function automatic void clear_hist();
        h_g.delete();
        h_a.delete();
        h_b.delete();
    endfunction

    always @(negedge clk) begin
        if (!rst && guess_valid) begin
            if (prev_valid) chk("guess_stable", guess, prev_guess);
            chk("guess_distinct", 32'(distinct(guess)), 32'd1);
            chk("guess_consistent", 32'(consistent(guess)), 32'd1);
        end
        if (!rst && (done || fail)) chk("end_flags", {busy, guess_valid, done & fail}, 3'b000);
        prev_valid <= guess_valid;
        prev_guess <= guess;
    end

    task automatic start_solve(input bit stray);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_hist();
        chk("start_flags", {busy, done, fail, guess_valid}, 4'b1000);
        chk("start_num", 32'(guess_num), 32'd0);
        if (stray) begin
            @(negedge clk);
            start = 1'b1; score_valid = 1'b1; a_in = 3'd4; b_in = 3'd0;
            @(posedge clk);
            #1;
            start = 1'b0; score_valid = 1'b0;
        end
    endtask

    task automatic expect_guess(input logic [15:0] exp);
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (guess_valid || done || fail) break;
        end
        chk("guess_valid", 32'(guess_valid), 32'd1);
        chk("guess", 32'(guess), 32'(exp));
        chk("guess_num_before", 32'(guess_num), 32'(h_g.size()));
    endtask

    task automatic send_score(input int a, input int b, input int dly);
        repeat (dly) @(negedge clk);
        score_valid = 1'b1; a_in = 3'(a); b_in = 3'(b);
        @(posedge clk);
        #1;
        score_valid = 1'b0;
        chk("valid_drop", 32'(guess_valid), 32'd0);
        if (a + b <= 4 && !(a == 3 && b == 1)) begin
            h_g.push_back(prev_guess);
            h_a.push_back(a);
            h_b.push_back(b);
        end
    endtask

    task automatic wait_end();
        bit saw = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (done || fail) break;
            saw |= guess_valid;
        end
        chk("no_guess_while_searching", 32'(saw), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_values", {guess, guess_valid, guess_num, busy, done, fail}, 24'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_hist();
    endtask

    task automatic solve_secret(input logic [15:0] secret, input bit stray);
        logic [16:0] nx;
        int s;
        start_solve(stray);
        for (int k = 0; k < 12; k++) begin
            nx = model_next();
            if (!nx[16]) begin
                wait_end();
                chk("solve_fail", {done, fail}, 2'b01);
                chk("solve_fail_num", 32'(guess_num), 32'(h_g.size()));
                return;
            end
            expect_guess(nx[15:0]);
            s = score(nx[15:0], secret);
            send_score(s / 10, s % 10, int'($urandom_range(0, 3)));
            chk("guess_num_after", 32'(guess_num), 32'(h_g.size()));
            if (s == 40) begin
                chk("solve_done", {done, fail, busy}, 3'b100);
                return;
            end
            if (h_g.size() == 10) begin
                chk("solve_max", {done, fail, busy}, 3'b010);
                return;
            end
        end
    endtask

    task automatic wait_gv2();
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (gv2 || done2 || fail2) break;
        end
        chk("gv2", 32'(gv2), 32'd1);
    endtask

    initial begin
        logic [16:0] nx;
        logic [15:0] sec;
        int d[4];

        repeat (2) @(negedge clk);
        chk("reset_state", {guess, guess_valid, guess_num, busy, done, fail}, 24'h0);
        chk("reset_state2", {g2, gv2, gn2, busy2, done2, fail2}, 24'h0);
        rst = 1'b0;

        // Pin the model with hand-worked values.
        chk("model_score_0a4b", 32'(score(16'h0123, 16'h1032)), 32'd4);
        chk("model_score_2a2b", 32'(score(16'h1234, 16'h1243)), 32'd22);
        chk("model_score_0a0b", 32'(score(16'h5678, 16'h0123)), 32'd0);
        nx = model_next();
        chk("model_first", 32'(nx), 32'h10123);
        h_g.push_back(16'h0123); h_a.push_back(0); h_b.push_back(0);
        nx = model_next();
        chk("model_after_0a0b", 32'(nx), 32'h14567);
        clear_hist();

        // Secret 0123, with first-guess latency.
        start_solve(1'b0);
        @(posedge clk);
        #1;
        chk("lat_edge1_valid", 32'(guess_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", 32'(guess_valid), 32'd1);
        chk("lat_edge2_guess", 32'(guess), 32'h0123);
        expect_guess(16'h0123);
        send_score(4, 0, 0);
        chk("t1_flags", {done, fail, busy}, 3'b100);
        chk("t1_num", 32'(guess_num), 32'd1);

        // Stray score in DONE changes nothing.
        send_score(0, 0, 1);
        chk("stray_done", {done, guess_num, guess}, {1'b1, 4'd1, 16'h0123});
        clear_hist();
        h_g.push_back(16'h0123); h_a.push_back(4); h_b.push_back(0);

        // Secret 4567, with a stray start while the guess is pending.
        start_solve(1'b1);
        expect_guess(16'h0123);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("stray_start_propose", {guess_valid, busy, guess}, {2'b11, 16'h0123});
        send_score(0, 0, 0);
        expect_guess(16'h4567);
        send_score(4, 0, 2);
        chk("t2_flags", {done, fail, busy}, 3'b100);
        chk("t2_num", 32'(guess_num), 32'd2);

        // Contradictory scores exhaust the candidates.
        start_solve(1'b0);
        expect_guess(16'h0123);
        send_score(0, 0, 1);
        expect_guess(16'h4567);
        send_score(0, 0, 0);
        wait_end();
        chk("t3_flags", {done, fail, busy}, 3'b010);
        chk("t3_num", 32'(guess_num), 32'd2);

        // Illegal 3A1B.
        start_solve(1'b0);
        expect_guess(16'h0123);
        send_score(3, 1, 0);
        chk("t4_flags", {done, fail, busy, guess_valid}, 4'b0100);
        chk("t4_num", 32'(guess_num), 32'd0);

        // MAX_GUESS=2, secret 9876.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_gv2();
        chk("t5_g0", 32'(g2), 32'h0123);
        sv2 = 1'b1; a2 = 3'd0; b2 = 3'd0;
        @(posedge clk);
        #1;
        sv2 = 1'b0;
        wait_gv2();
        chk("t5_g1", 32'(g2), 32'h4567);
        sv2 = 1'b1; a2 = 3'd0; b2 = 3'd2;
        @(posedge clk);
        #1;
        sv2 = 1'b0;
        chk("t5_flags", {done2, fail2, busy2, gv2}, 4'b0100);
        chk("t5_num", 32'(gn2), 32'd2);

        // Reset mid-PROPOSE and mid-SEARCH, then a stray score while idle.
        start_solve(1'b0);
        expect_guess(16'h0123);
        apply_reset();
        start_solve(1'b0);
        expect_guess(16'h0123);
        send_score(0, 0, 0);
        repeat (3) @(negedge clk);
        chk("mid_search", {busy, guess_valid}, 2'b10);
        apply_reset();
        send_score(4, 0, 1);
        chk("stray_idle", {guess, guess_valid, guess_num, busy, done, fail}, 24'h0);
        clear_hist();

        // Assorted secrets, leading digit kept low to bound scan length.
        for (int r = 0; r < 5; r++) begin
            d[3] = int'($urandom_range(0, 4));
            do d[2] = int'($urandom_range(0, 9)); while (d[2] == d[3]);
            do d[1] = int'($urandom_range(0, 9)); while (d[1] == d[3] || d[1] == d[2]);
            do d[0] = int'($urandom_range(0, 9));
            while (d[0] == d[3] || d[0] == d[2] || d[0] == d[1]);
            sec = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
            solve_secret(sec, 1'(r % 2));
        end
        solve_secret(16'h1032, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
